// File: rtl/data_read_ctrl.sv
// Captures a fixed-length burst of source words into a buffer under CR start/abort control.
// One-cycle buffer write latency; no buffer backpressure; src_ready is asserted only while capturing.
module data_read_ctrl #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESET,
  input  logic             cr_start,
  input  logic             cr_abort,
  input  logic [LEN_W-1:0] cr_len,
  input  logic             src_valid,
  input  logic [31:0]      src_data,
  output logic             src_ready,
  output logic             buf_we,
  output logic [LEN_W-1:0] buf_addr,
  output logic [31:0]      buf_wdata,
  output logic             sr_busy,
  output logic             sr_done,
  output logic             sr_timeout,
  output logic [LEN_W-1:0] word_cnt,
  output logic             irq
);

  // Idle counter only needs to reach TIMEOUT-1.
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [IDLE_W-1:0] idle_cnt;

  assign src_ready = (state == S_CAPTURE);
  assign sr_busy   = (state != S_IDLE);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idle_cnt   <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      sr_done    <= 1'b0;
      sr_timeout <= 1'b0;
      word_cnt   <= '0;
      irq        <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      irq    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cr_start) begin
            word_cnt   <= '0;
            sr_timeout <= 1'b0;
            if (cr_len != '0) begin
              len_q    <= cr_len;
              sr_done  <= 1'b0;
              idle_cnt <= '0;
              state    <= S_CAPTURE;
            end else begin
              state <= S_DONE;
              irq   <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          // Abort wins over a same-cycle accept: that word is dropped.
          if (cr_abort) begin
            state <= S_IDLE;
          end else if (src_valid) begin
            buf_we    <= 1'b1;
            buf_addr  <= word_cnt;
            buf_wdata <= src_data;
            word_cnt  <= word_cnt + 1'b1;
            idle_cnt  <= '0;
            if (word_cnt == len_q - 1'b1) begin
              state <= S_DONE;
              irq   <= 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state <= S_ERR;
            irq   <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_DONE: begin
          sr_done <= 1'b1;
          state   <= S_IDLE;
        end
        S_ERR: begin
          sr_timeout <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_read_ctrl.sv
// Random and directed checking of data_read_ctrl against a transaction-level model.
module tb_data_read_ctrl;

  localparam int LW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] len = '0;
  logic          valid = 1'b0;
  logic [31:0]   data = '0;

  logic          src_ready, buf_we, sr_busy, sr_done, sr_timeout, irq;
  logic [LW-1:0] buf_addr, word_cnt;
  logic [31:0]   buf_wdata;

  data_read_ctrl #(.LEN_W(LW), .TIMEOUT(TO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .cr_start(start), .cr_abort(abort), .cr_len(len),
    .src_valid(valid), .src_data(data), .src_ready(src_ready),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .sr_busy(sr_busy), .sr_done(sr_done), .sr_timeout(sr_timeout),
    .word_cnt(word_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: transfer in flight, words still owed, and a pending completion pulse
  // (0 none, 1 normal finish, 2 timeout).
  bit          m_cap;
  int          m_len, m_cnt, m_idle, m_fin;
  bit          m_done, m_to, m_we;
  int          m_addr;
  logic [31:0] m_wdata;

  int          wq[$];
  logic [31:0] dq[$];
  int          irq_n, rdy_n, irq_at, fall_at;
  bit          prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_len = 0; m_cnt = 0; m_idle = 0; m_fin = 0;
    m_done = 0; m_to = 0; m_we = 0; m_addr = 0; m_wdata = '0;
  endtask

  task automatic model_step();
    m_we = 0;
    if (m_fin != 0) begin
      if (m_fin == 1) m_done = 1; else m_to = 1;
      m_fin = 0;
    end else if (!m_cap) begin
      if (start) begin
        m_cnt = 0; m_to = 0;
        if (len != 0) begin
          m_cap = 1; m_len = int'(len); m_done = 0; m_idle = 0;
        end else begin
          m_fin = 1;
        end
      end
    end else if (abort) begin
      m_cap = 0;
    end else if (valid) begin
      m_we = 1; m_addr = m_cnt; m_wdata = data;
      m_cnt++; m_idle = 0;
      if (m_cnt == m_len) begin m_cap = 0; m_fin = 1; end
    end else if (m_idle == TO - 1) begin
      m_cap = 0; m_fin = 2;
    end else begin
      m_idle++;
    end
  endtask

  task automatic check_all();
    cyc++;
    chk("src_ready", 32'(src_ready), 32'(m_cap));
    chk("buf_we", 32'(buf_we), 32'(m_we));
    chk("buf_addr", 32'(buf_addr), m_addr);
    chk("buf_wdata", buf_wdata, m_wdata);
    chk("sr_busy", 32'(sr_busy), 32'(m_cap || m_fin != 0));
    chk("sr_done", 32'(sr_done), 32'(m_done));
    chk("sr_timeout", 32'(sr_timeout), 32'(m_to));
    chk("word_cnt", 32'(word_cnt), m_cnt);
    chk("irq", 32'(irq), 32'(m_fin != 0));
    if (buf_we) begin wq.push_back(int'(buf_addr)); dq.push_back(buf_wdata); end
    if (irq) begin irq_n++; irq_at = cyc; end
    if (src_ready) rdy_n++;
    if (prev_busy && !sr_busy) fall_at = cyc;
    prev_busy = sr_busy;
  endtask

  task automatic clear_obs();
    wq.delete(); dq.delete();
    irq_n = 0; rdy_n = 0; irq_at = -1; fall_at = -1;
  endtask

  task automatic drive(input bit st, input bit ab, input int ln, input bit v, input logic [31:0] d);
    start = st; abort = ab; len = LW'(ln); valid = v; data = d;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(src_ready), 0);
    chk({tag, "_we"}, 32'(buf_we), 0);
    chk({tag, "_addr"}, 32'(buf_addr), 0);
    chk({tag, "_wdata"}, buf_wdata, 0);
    chk({tag, "_busy"}, 32'(sr_busy), 0);
    chk({tag, "_done"}, 32'(sr_done), 0);
    chk({tag, "_timeout"}, 32'(sr_timeout), 0);
    chk({tag, "_cnt"}, 32'(word_cnt), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
  endtask

  int p4_cyc;
  int quiet;

  initial begin
    model_reset();
    clear_obs();
    prev_busy = 0;
    @(negedge clk);
    chk_zero_outputs("rst");
    rst = 1'b0;

    // Four words with src_valid held high.
    clear_obs();
    drive(1, 0, 4, 0, 0); cycle();
    for (int k = 0; k < 8; k++) begin drive(0, 0, 0, 1, 32'hA0 + k); cycle(); end
    chk("s1_ready_cycles", rdy_n, 4);
    chk("s1_writes", wq.size(), 4);
    for (int i = 0; i < 4; i++) if (i < wq.size()) begin
      chk("s1_addr", wq[i], i);
      chk("s1_data", dq[i], 32'hA0 + i);
    end
    chk("s1_done", 32'(sr_done), 1);
    chk("s1_irqs", irq_n, 1);
    chk("s1_cnt", 32'(word_cnt), 4);

    // Three words with gaps in src_valid.
    clear_obs();
    drive(1, 0, 3, 0, 0); cycle();
    for (int k = 0; k < 5; k++) begin drive(0, 0, 0, (k % 2) == 0, 32'hC0 + k); cycle(); end
    p4_cyc = cyc;
    for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 0, 0); cycle(); end
    chk("s2_writes", wq.size(), 3);
    for (int i = 0; i < 3; i++) if (i < wq.size()) chk("s2_addr", wq[i], i);
    chk("s2_irqs", irq_n, 1);
    chk("s2_irq_at", irq_at, p4_cyc);
    chk("s2_busy_fall", fall_at, p4_cyc + 1);

    // Timeout after two words.
    clear_obs();
    drive(1, 0, 5, 0, 0); cycle();
    for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 1, 32'hD0 + k); cycle(); end
    for (int k = 0; k < 14; k++) begin drive(0, 0, 0, 0, 0); cycle(); end
    chk("s3_ready_cycles", rdy_n, 10);
    chk("s3_timeout", 32'(sr_timeout), 1);
    chk("s3_done", 32'(sr_done), 0);
    chk("s3_cnt", 32'(word_cnt), 2);
    chk("s3_irqs", irq_n, 1);

    // Abort on the second accept; a start during capture is ignored.
    clear_obs();
    drive(1, 0, 4, 0, 0); cycle();
    drive(1, 0, 2, 1, 32'hB0); cycle();
    drive(0, 1, 0, 1, 32'hB1); cycle();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 1, 32'hB2 + k); cycle(); end
    chk("s4_writes", wq.size(), 1);
    chk("s4_irqs", irq_n, 0);
    chk("s4_cnt", 32'(word_cnt), 1);
    chk("s4_busy", 32'(sr_busy), 0);
    chk("s4_done", 32'(sr_done), 0);
    chk("s4_timeout", 32'(sr_timeout), 0);

    // Zero-length start.
    clear_obs();
    drive(1, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 0); cycle(); end
    chk("s5_done", 32'(sr_done), 1);
    chk("s5_irqs", irq_n, 1);
    chk("s5_writes", wq.size(), 0);
    chk("s5_cnt", 32'(word_cnt), 0);

    // Asynchronous reset in the middle of a capture.
    drive(1, 0, 6, 0, 0); cycle();
    for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 1, 32'hE0 + k); cycle(); end
    drive(0, 0, 0, 1, 32'hE2);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    clear_obs();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 0, 1, 32'hE3 + k); cycle(); end
    chk("arst_writes", wq.size(), 0);
    chk("arst_irqs", irq_n, 0);

    // Randomized traffic.
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      if (quiet == 0 && $urandom_range(0, 49) == 0) quiet = $urandom_range(5, 12);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 6),
            (quiet == 0) && ($urandom_range(0, 3) != 0), $urandom);
      if (quiet > 0) quiet--;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
